// File: rtl/ctrl_seq.sv
// Control sequencer for the 8-bit CPU: T1-T6 ring, opcode decode and Moore control strobes.
// Optional CTRL_SEQ_SINGLE_STEP_EN adds a step input that gates every state transition.
module ctrl_seq (
  input  logic       clk,
  input  logic       rst,
`ifdef CTRL_SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [3:0] ir_op_4,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_in,
  output logic       halt,
  output logic       instr_done,
  output logic [7:0] icount_8
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StT1   = 3'd1;
  localparam logic [2:0] StT2   = 3'd2;
  localparam logic [2:0] StT3   = 3'd3;
  localparam logic [2:0] StT4   = 3'd4;
  localparam logic [2:0] StT5   = 3'd5;
  localparam logic [2:0] StT6   = 3'd6;
  localparam logic [2:0] StHalt = 3'd7;

  localparam logic [3:0] OpLda = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpOut = 4'b1110;
  localparam logic [3:0] OpHlt = 4'b1111;

  logic [2:0] state_q, state_d;
  logic [7:0] icount_q, icount_d;
  logic       adv;

`ifdef CTRL_SEQ_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    icount_d = icount_q;
    if (adv) begin
      case (state_q)
        StIdle: state_d = StT1;
        StT1:   state_d = StT2;
        StT2:   state_d = StT3;
        StT3:   state_d = StT4;
        StT4:   state_d = (ir_op_4 == OpHlt) ? StHalt : StT5;
        StT5:   state_d = StT6;
        StT6: begin
          state_d  = StT1;
          icount_d = icount_q + 8'd1;
        end
        default: state_d = StHalt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      icount_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  end

  assign icount_8 = icount_q;

  // Moore decode; execute states additionally look at the opcode held in the IR.
  always_comb begin
    pc_out     = 1'b0;
    pc_inc     = 1'b0;
    mar_in     = 1'b0;
    ram_out    = 1'b0;
    ir_in      = 1'b0;
    ir_out     = 1'b0;
    a_in       = 1'b0;
    a_out      = 1'b0;
    b_in       = 1'b0;
    alu_sub    = 1'b0;
    alu_out    = 1'b0;
    out_in     = 1'b0;
    halt       = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      StT1: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
      end
      StT2: pc_inc = 1'b1;
      StT3: begin
        ram_out = 1'b1;
        ir_in   = 1'b1;
      end
      StT4: begin
        if (ir_op_4 == OpLda || ir_op_4 == OpAdd || ir_op_4 == OpSub) begin
          ir_out = 1'b1;
          mar_in = 1'b1;
        end else if (ir_op_4 == OpOut) begin
          a_out  = 1'b1;
          out_in = 1'b1;
        end
      end
      StT5: begin
        if (ir_op_4 == OpLda) begin
          ram_out = 1'b1;
          a_in    = 1'b1;
        end else if (ir_op_4 == OpAdd || ir_op_4 == OpSub) begin
          ram_out = 1'b1;
          b_in    = 1'b1;
        end
      end
      StT6: begin
        instr_done = 1'b1;
        if (ir_op_4 == OpAdd || ir_op_4 == OpSub) begin
          alu_out = 1'b1;
          a_in    = 1'b1;
          alu_sub = (ir_op_4 == OpSub);
        end
      end
      StHalt: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed instruction sequence with random don't-care opcodes,
// compared every cycle against a phase-counter reference model.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ir_op_4 = 4'd0;
  logic       step_v = 1'b1;
  logic       pc_out, pc_inc, mar_in, ram_out, ir_in, ir_out, a_in, a_out, b_in;
  logic       alu_sub, alu_out, out_in, halt, instr_done;
  logic [7:0] icount_8;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1..6 = T-cycle, 7 = halted.
  int m_phase = 0;
  int m_cnt   = 0;

  localparam int PcOut = 0, PcInc = 1, MarIn = 2, RamOut = 3, IrIn = 4, IrOut = 5, AIn = 6;
  localparam int AOut = 7, BIn = 8, AluSub = 9, AluOut = 10, OutIn = 11, Halt = 12, Done = 13;

  always #5 clk = ~clk;

`ifdef CTRL_SEQ_SINGLE_STEP_EN
  logic step;
  assign step = step_v;
`endif

  ctrl_seq dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .ir_op_4    (ir_op_4),
    .pc_out     (pc_out),
    .pc_inc     (pc_inc),
    .mar_in     (mar_in),
    .ram_out    (ram_out),
    .ir_in      (ir_in),
    .ir_out     (ir_out),
    .a_in       (a_in),
    .a_out      (a_out),
    .b_in       (b_in),
    .alu_sub    (alu_sub),
    .alu_out    (alu_out),
    .out_in     (out_in),
    .halt       (halt),
    .instr_done (instr_done),
    .icount_8   (icount_8)
  );

  function automatic logic [13:0] exp_ctrl(input int ph, input logic [3:0] op);
    logic [13:0] v;
    logic mem_op;
    v = '0;
    mem_op = (op == 4'd0) || (op == 4'd1) || (op == 4'd2);
    case (ph)
      1: begin v[PcOut] = 1'b1; v[MarIn] = 1'b1; end
      2: v[PcInc] = 1'b1;
      3: begin v[RamOut] = 1'b1; v[IrIn] = 1'b1; end
      4: begin
        if (mem_op) begin v[IrOut] = 1'b1; v[MarIn] = 1'b1; end
        if (op == 4'd14) begin v[AOut] = 1'b1; v[OutIn] = 1'b1; end
      end
      5: begin
        if (mem_op) v[RamOut] = 1'b1;
        if (op == 4'd0) v[AIn] = 1'b1;
        if (op == 4'd1 || op == 4'd2) v[BIn] = 1'b1;
      end
      6: begin
        v[Done] = 1'b1;
        if (op == 4'd1 || op == 4'd2) begin
          v[AluOut] = 1'b1;
          v[AIn]    = 1'b1;
          v[AluSub] = (op == 4'd2);
        end
      end
      7: v[Halt] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic model_advance(input logic [3:0] op);
    if (step_v && m_phase != 7) begin
      if (m_phase == 6) begin
        m_phase = 1;
        m_cnt   = (m_cnt + 1) % 256;
      end else if (m_phase == 4 && op == 4'd15) begin
        m_phase = 7;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [13:0] obs, exp;
    logic [4:0]  bus;
    obs = {instr_done, halt, out_in, alu_out, alu_sub, b_in, a_out, a_in, ir_out, ir_in,
           ram_out, mar_in, pc_inc, pc_out};
    exp = exp_ctrl(m_phase, ir_op_4);
    bus = {pc_out, ram_out, ir_out, a_out, alu_out};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ctrl: observed %h expected %h (phase %0d op %0d)", tag, obs, exp,
             m_phase, ir_op_4);
    end
    checks++;
    assert (icount_8 === 8'(m_cnt)) else begin
      errors++;
      $error("FAIL %s icount: observed %0d expected %0d", tag, icount_8, m_cnt);
    end
    checks++;
    assert ($countones(bus) <= 1) else begin
      errors++;
      $error("FAIL %s bus: observed drivers %b expected at most one", tag, bus);
    end
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input logic [3:0] op, input string tag);
    ir_op_4 = op;
    #1;
    check(tag);
    @(posedge clk);
    model_advance(op);
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [3:0] op, input string tag);
    for (int i = 0; i < 3; i++) cycle(4'($urandom_range(0, 15)), tag);
    for (int i = 0; i < 3; i++) cycle(op, tag);
  endtask

  // Leaves the sequencer in T1.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    m_phase = 0;
    m_cnt   = 0;
    #1;
    check(tag);
    @(negedge clk);
    rst = 1'b0;
    cycle(4'($urandom_range(0, 15)), tag);
  endtask

  initial begin
    @(negedge clk);
    do_reset("reset");

    run_instr(4'd0, "lda");
    run_instr(4'd2, "sub");
    run_instr(4'd1, "add");

    do_reset("reset_out");
    run_instr(4'd14, "out");
    run_instr(4'd15, "hlt");
    for (int i = 0; i < 20; i++) cycle(4'($urandom_range(0, 15)), "halted");

    do_reset("reset_nop");
    for (int i = 0; i < 256; i++) run_instr(4'd5, "nop_wrap");
    for (int i = 0; i < 30; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_instr(op, "random");
    end

    // Reset abandons an ADD in T5.
    for (int i = 0; i < 4; i++) cycle(4'd1, "add_pre_rst");
    ir_op_4 = 4'd1;
    #1;
    check("add_t5");
    #2;
    rst = 1'b1;
    m_phase = 0;
    m_cnt   = 0;
    #1;
    check("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle(4'd1, "post_rst_idle");
    run_instr(4'd1, "add_after_rst");

`ifdef CTRL_SEQ_SINGLE_STEP_EN
    do_reset("reset_step");
    cycle(4'd0, "step_t1");
    cycle(4'd0, "step_t2");
    step_v = 1'b0;
    for (int i = 0; i < 10; i++) cycle(4'($urandom_range(0, 15)), "step_freeze");
    for (int i = 0; i < 16; i++) begin
      step_v = (i % 2 == 0);
      cycle(4'd1, "step_pulse");
    end
    step_v = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
